// File: rtl/drum_trigger_processor.sv
// Drum trigger processor: detects accel_z strikes with hysteresis and refractory lockout,
// zones the yaw heading into a drum code, queues codes and hands them out one per downstream ack.
//
// Detect FSM
//   state   | meaning
//   ARMED   | waiting for accel_z to reach STRIKE_THRESH
//   STRIKE  | strike in progress, waiting for accel_z to fall to RELEASE_THRESH
//   REFRACT | lockout, counting down REFRACT_CYCLES
// TX FSM
//   state   | meaning
//   TX_IDLE | free to pop the next queued code
//   TX_WAIT | code issued, waiting for command_sent or ack timeout
module drum_trigger_processor #(
  parameter logic signed [15:0] STRIKE_THRESH  = 16'sd12000,
  parameter logic signed [15:0] RELEASE_THRESH = 16'sd4000,
  parameter logic [23:0]        REFRACT_CYCLES = 24'd1_200_000,
  parameter logic [7:0]         YAW_OFFSET     = 8'd16,
  parameter logic [15:0]        ACK_TIMEOUT    = 16'd60000,
  parameter int                 FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [15:0] accel_z,
  input  logic [7:0]         yaw,
  input  logic               command_sent,
  output logic               drum_trigger_valid,
  output logic [3:0]         drum_code,
  output logic               overflow,
  output logic [2:0]         pending
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0]    DEPTH_C = 3'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {ARMED, STRIKE, REFRACT} det_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

  det_state_t det_state, det_next;
  tx_state_t  tx_state, tx_next;

  logic [23:0]   refract_cnt;
  logic [15:0]   ack_timer;
  logic [7:0]    yaw_adj;
  logic [2:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          push, pop, full, do_push;

  assign yaw_adj = yaw + YAW_OFFSET;
  assign full    = (count == DEPTH_C);
  assign do_push = push && (!full || pop);
  assign pending = count;

  always_comb begin
    det_next = det_state;
    push     = 1'b0;
    case (det_state)
      ARMED: begin
        if (sample_valid && (accel_z >= STRIKE_THRESH)) begin
          det_next = STRIKE;
          push     = 1'b1;
        end
      end
      STRIKE: begin
        if (sample_valid && (accel_z <= RELEASE_THRESH)) det_next = REFRACT;
      end
      REFRACT: begin
        // leave on the cycle the counter steps down to zero
        if (refract_cnt <= 24'd1) det_next = ARMED;
      end
      default: det_next = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      det_state   <= ARMED;
      refract_cnt <= '0;
    end else begin
      det_state <= det_next;
      if (det_state == STRIKE && det_next == REFRACT)
        refract_cnt <= REFRACT_CYCLES;
      else if (det_state == REFRACT && refract_cnt != 24'd0)
        refract_cnt <= refract_cnt - 24'd1;
    end
  end

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (count != 3'd0) begin
          pop     = 1'b1;
          tx_next = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (command_sent || ack_timer <= 16'd1) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= yaw_adj[7:5];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)     rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      count <= count + {2'b00, do_push} - {2'b00, pop};
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state           <= TX_IDLE;
      ack_timer          <= '0;
      drum_trigger_valid <= 1'b0;
      drum_code          <= '0;
    end else begin
      tx_state           <= tx_next;
      drum_trigger_valid <= pop;
      if (pop) begin
        drum_code <= {1'b0, fifo_mem[rd_ptr]};
        ack_timer <= ACK_TIMEOUT;
      end else if (tx_state == TX_WAIT && ack_timer != 16'd0) begin
        ack_timer <= ack_timer - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_drum_trigger_processor.sv
// Scoreboard bench for drum_trigger_processor: stimulus queues expected drum codes,
// a monitor pops and compares them on every drum_trigger_valid pulse.
module tb_drum_trigger_processor;
  localparam int R = 20;
  localparam int T = 300;

  logic clk = 1'b0;
  logic reset, sample_valid, command_sent;
  logic signed [15:0] accel_z;
  logic [7:0] yaw;
  logic drum_trigger_valid, overflow;
  logic [3:0] drum_code;
  logic [2:0] pending;

  drum_trigger_processor #(
    .STRIKE_THRESH(16'sd12000), .RELEASE_THRESH(16'sd4000),
    .REFRACT_CYCLES(24'(R)), .YAW_OFFSET(8'd16),
    .ACK_TIMEOUT(16'(T)), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .accel_z(accel_z),
    .yaw(yaw), .command_sent(command_sent), .drum_trigger_valid(drum_trigger_valid),
    .drum_code(drum_code), .overflow(overflow), .pending(pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  int exp_q[$];
  int pulses = 0, last_pulse = -1, prev_pulse = -1;
  bit prev_valid = 0;
  bit auto_ack = 0;
  int ack_req = 0, ack_done = 0, ack_timer = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int code_of(input int y);
    return ((y + 16) % 256) >> 5;
  endfunction

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 0;
        continue;
      end
      if (drum_trigger_valid) begin
        chk("pulse_width_one", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse code=%0d required=no pulse (cycle %0d)", drum_code, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("drum_code", int'(drum_code), e);
        end
        prev_pulse = last_pulse;
        last_pulse = cyc;
        pulses++;
      end
      prev_valid = drum_trigger_valid;
    end
  endtask

  task automatic ack_driver();
    forever begin
      @(negedge clk);
      command_sent = 1'b0;
      if (reset) ack_timer = 0;
      else if (auto_ack && drum_trigger_valid) ack_timer = 5;
      else if (ack_timer > 0) begin
        ack_timer--;
        if (ack_timer == 0) command_sent = 1'b1;
      end
      if (ack_req != ack_done) begin
        command_sent = 1'b1;
        ack_done++;
      end
    end
  endtask

  task automatic sample(input int z, input int y, output int c);
    @(negedge clk);
    c = cyc;
    sample_valid = 1'b1;
    accel_z = 16'(z);
    yaw = 8'(y);
    @(negedge clk);
    sample_valid = 1'b0;
    accel_z = '0;
  endtask

  task automatic strike(input int y, input bit accept);
    int c;
    if (accept) exp_q.push_back(code_of(y));
    sample(13000, y, c);
    sample(2000, y, c);
    repeat (R + 5) @(negedge clk);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int c, c0, p0;
    reset = 1'b1; sample_valid = 1'b0; accel_z = '0; yaw = '0; command_sent = 1'b0;
    fork
      monitor();
      ack_driver();
      begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_valid", int'(drum_trigger_valid), 0);
    chk("rst_code", int'(drum_code), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_pending", int'(pending), 0);
    reset = 1'b0;

    // single hit, ack five cycles after the pulse
    auto_ack = 1;
    sample(0, 40, c);
    exp_q.push_back(1);
    sample(13000, 40, c0);
    sample(2000, 40, c);
    wait_empty(20, "single_hit_seen");
    chk("latency", last_pulse - c0, 2);
    repeat (10) @(negedge clk);
    chk("pending_after_ack", int'(pending), 0);
    repeat (R + 5) @(negedge clk);

    // hysteresis and refractory lockout
    p0 = pulses;
    exp_q.push_back(code_of(40));
    sample(13000, 40, c);
    sample(8000, 100, c);
    sample(13000, 100, c);
    sample(8000, 100, c);
    sample(2000, 100, c);
    repeat (3) @(negedge clk);
    sample(13000, 200, c);
    sample(2000, 200, c);
    repeat (R + 5) @(negedge clk);
    strike(130, 1);
    wait_empty(50, "hyst_queue_empty");
    repeat (10) @(negedge clk);
    chk("hyst_pulse_count", pulses - p0, 2);

    // yaw wrap and ack timeout
    auto_ack = 0;
    p0 = pulses;
    strike(250, 1);
    strike(40, 1);
    wait_empty(T + 50, "timeout_queue_empty");
    chk("timeout_interval", last_pulse - prev_pulse, T + 1);
    repeat (T + 10) @(negedge clk);
    ack_req++;
    repeat (20) @(negedge clk);
    chk("late_ack_no_pulse", pulses - p0, 2);
    auto_ack = 1;
    strike(0, 1);
    wait_empty(20, "post_timeout_strike");

    // overflow: one issued, four queued, sixth dropped
    auto_ack = 0;
    repeat (10) @(negedge clk);
    strike(0, 1);
    strike(32, 1);
    strike(64, 1);
    strike(96, 1);
    strike(128, 1);
    strike(160, 0);
    chk("ovf_pending", int'(pending), 4);
    chk("ovf_flag", int'(overflow), 1);
    auto_ack = 1;
    ack_req++;
    wait_empty(200, "ovf_drain");
    repeat (10) @(negedge clk);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_pending_drained", int'(pending), 0);

    // reset in TX_WAIT with three queued and detect FSM mid-strike
    auto_ack = 0;
    strike(0, 1);
    strike(32, 1);
    strike(64, 1);
    exp_q.push_back(code_of(96));
    sample(13000, 96, c);
    repeat (2) @(negedge clk);
    chk("mid_pending", int'(pending), 3);
    chk("mid_overflow", int'(overflow), 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", int'(drum_trigger_valid), 0);
    chk("mid_rst_code", int'(drum_code), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_pending", int'(pending), 0);
    p0 = pulses;
    repeat (30) @(negedge clk);
    chk("no_pulse_after_reset", pulses - p0, 0);
    auto_ack = 1;
    strike(200, 1);
    wait_empty(20, "fresh_strike_after_reset");
    chk("fresh_strike_count", pulses - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/drum_trigger_processor.md
DRUM_TRIGGER_PROCESSOR -- requirements
Module: drum_trigger_processor

Interface
REQ-001 SHALL have parameter STRIKE_THRESH, default 16'sd12000, signed accel_z level that declares a strike.
REQ-002 SHALL have parameter RELEASE_THRESH, default 16'sd4000, signed accel_z level that ends a strike (hysteresis).
REQ-003 SHALL have parameter REFRACT_CYCLES, default 24'd1_200_000, clk cycles of lockout after release.
REQ-004 SHALL have parameter YAW_OFFSET, default 8'd16, added to yaw before zoning.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 16'd60000, clk cycles to wait for command_sent.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, trigger queue depth.
REQ-007 clk  input  1  system clock; single clock domain, all logic on posedge clk.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 sample_valid  input  1  one-cycle strobe: accel_z and yaw valid this cycle.
REQ-010 accel_z  input  16  signed vertical acceleration sample.
REQ-011 yaw  input  8  unsigned heading, 0..255 = 0..360 deg.
REQ-012 command_sent  input  1  one-cycle ack from downstream SPI slave.
REQ-013 drum_trigger_valid  output  1  one-cycle pulse presenting drum_code.
REQ-014 drum_code  output  4  drum code 0..7; bit 3 always 0.
REQ-015 overflow  output  1  sticky flag: a trigger was dropped.
REQ-016 pending  output  3  FIFO occupancy 0..FIFO_DEPTH.

Function
REQ-017 Detect FSM states SHALL be ARMED, STRIKE, REFRACT; only sample_valid cycles evaluate thresholds.
REQ-018 ARMED -> STRIKE when sample_valid and accel_z >= STRIKE_THRESH (signed compare); same cycle a code is pushed.
REQ-019 Pushed code SHALL be zone = ((yaw + YAW_OFFSET) mod 256) >> 5, 8-bit wrap, zero-extended to 4 bits.
REQ-020 STRIKE -> REFRACT when sample_valid and accel_z <= RELEASE_THRESH; no push while in STRIKE or REFRACT.
REQ-021 REFRACT SHALL load counter with REFRACT_CYCLES on entry, decrement every clk, -> ARMED when counter reaches 0, independent of sample_valid.
REQ-022 FIFO: push when not full or pop same cycle; push when full and no pop SHALL drop the code and set overflow; overflow clears only on reset.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; pending SHALL equal writes minus reads, registered.
REQ-024 TX FSM states SHALL be TX_IDLE, TX_WAIT.
REQ-025 TX_IDLE with FIFO non-empty: pop head, register it to drum_code, assert drum_trigger_valid next cycle for exactly 1 cycle, -> TX_WAIT.
REQ-026 TX_WAIT: command_sent -> TX_IDLE; else timeout counter reaching ACK_TIMEOUT -> TX_IDLE (entry not retried).
REQ-027 command_sent outside TX_WAIT SHALL be ignored.
REQ-028 drum_code SHALL hold last issued value between pulses.
REQ-029 Latency: crossing sample at cycle N with empty FIFO and TX_IDLE -> drum_trigger_valid high in cycle N+2.
REQ-030 Back-to-back triggers SHALL never present two drum_trigger_valid pulses without intervening ack or timeout.

Reset
REQ-031 Reset SHALL force detect FSM ARMED, TX FSM TX_IDLE, FIFO empty, counters 0.
REQ-032 Reset outputs: drum_trigger_valid=0, drum_code=0, overflow=0, pending=0.
REQ-033 Reset mid-strike or mid-TX_WAIT SHALL discard queued codes and pending ack; next crossing after reset treated as fresh.

Verification
REQ-034 Single hit: yaw=8'd40, accel_z 0 -> 13000 -> 2000 -> pulse at N+2, drum_code=1 ((40+16)>>5); ack at +5 -> TX_IDLE, pending=0.
REQ-035 Yaw wrap: yaw=8'd250 crossing -> drum_code=0 ((250+16) mod 256 = 10).
REQ-036 Hysteresis/refractory: accel_z oscillating 13000/8000 in STRIKE -> one push; second crossing during REFRACT -> none; crossing after REFRACT_CYCLES -> push.
REQ-037 Overflow: no ack, ACK_TIMEOUT large, 6 strikes -> 1 issued, 4 queued (pending=4), 6th dropped, overflow=1 and stays 1.
REQ-038 Timeout: strike, withhold command_sent -> TX_WAIT exits after ACK_TIMEOUT cycles; next queued code pulses; late command_sent ignored.
REQ-039 Reset mid-operation: pending=3 in TX_WAIT, assert reset 1 cycle -> all outputs at reset values, no pulse until new crossing.
